rr_cfg_regs: RTL and testbench
==============================

Name: rr_cfg_regs

Overview:
- AXI-lite register file that terminates the record/replay configuration bus, i.e. the high 1MB of BAR1 after the BAR1 interconnect split.
- Holds the record/replay control and buffer configuration registers that drive the logging/replay engines.
- Returns engine status and a 64-bit log counter to host software.
- Single outstanding read and single outstanding write; 32-bit data path.

Parameters:
- VERSION, 32'h0001_0000: value returned by the VERSION register.
- ADDR_LSB, 2: word-select low bit; addr[7:ADDR_LSB] is decoded.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- cfg_bus  rr_axi_lite_bus_t.master modport  -  AXI-lite from the interconnect; this block is the slave.
- record_busy  in  1  engine status.
- replay_busy  in  1  engine status.
- overflow_evt  in  1  single-cycle overflow event.
- log_cnt  in  64  free-running log count.
- record_en  out  1  CTRL[0].
- replay_en  out  1  CTRL[1].
- rr_reset_pulse  out  1  one-cycle pulse when CTRL[2] is written 1.
- buf_base  out  64  {BUF_BASE_HI, BUF_BASE_LO}.
- buf_size  out  32  BUF_SIZE.

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL: RW bits[1:0]; bit2 is write-1-pulse and reads 0.
  - 0x04 STATUS: RO {29'b0, overflow_sticky, replay_busy, record_busy}.
  - 0x08 BUF_BASE_LO: RW.
  - 0x0C BUF_BASE_HI: RW.
  - 0x10 BUF_SIZE: RW.
  - 0x14 LOG_CNT_LO: RO; reading it snapshots log_cnt[63:32] into a shadow register.
  - 0x18 LOG_CNT_HI: RO; returns the shadow.
  - 0x1C SCRATCH: RW.
  - 0x20 VERSION: RO.
  - 0x28 OVF_CLR: write-1 to bit0 clears overflow_sticky.
  - Every other offset is unmapped.
- Reset values:
  - All RW registers, shadow and overflow_sticky = 0.
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; rdata = 0; bresp = rresp = 0.
  - rr_reset_pulse = 0.
- Write path:
  - AW and W are captured independently into holding regs: awready = !aw_held, wready = !w_held.
  - Commit happens on the first cycle both are held and bvalid = 0. RW bytes are updated per wstrb. bvalid asserts the next cycle, with aw_held and w_held cleared at the same time.
  - bvalid holds until bready. New AW/W may be captured while bvalid is high, but commit waits until the B handshake completes.
  - bresp: 2'b00 for mapped offsets. 2'b10 (SLVERR) for unmapped offsets or writes to RO registers; these writes have no effect.
  - rr_reset_pulse is high exactly the cycle after commit of a CTRL write with wdata[2]=1 and wstrb[0]=1.
- Read path:
  - arready = !rvalid.
  - On the AR handshake, data is selected from register state of that cycle and registered. rvalid asserts the next cycle (1-cycle latency) and holds with stable rdata until rready.
  - Unmapped offset: rdata = 32'hDEAD_BEEF, rresp = 2'b10.
- Simultaneous events:
  - Read and write commit to the same register in the same cycle: the read returns the old value.
  - overflow_evt and an OVF_CLR commit in the same cycle: the set wins.
- Reset asserted mid-transaction drops all valids and held state in the next cycle; the pending transaction is lost.

Optional Feature:
- Macro RR_CFG_WR_COUNT_EN.
- Defined:
  - Offset 0x24 WR_CNT is RO {16'b0, cnt}.
  - cnt is a 16-bit count of successful (OKAY) write commits. It saturates at 16'hFFFF and resets to 0.
- Undefined: 0x24 is unmapped (SLVERR, DEAD_BEEF).

Decomposition:
- Package rr_cfg_pkg:
  - Register offset localparams.
  - CTRL bit index constants.
  - AXI_RESP_OKAY/SLVERR constants.
  - RR_CFG_UNMAPPED_DATA.
- One sub-module, rr_cfg_axil_slave_if: owns the AW/W/B/AR/R handshakes. It presents wr_en, wr_addr, wr_data, wr_strb, wr_err_in and rd_en, rd_addr, rd_data, rd_err_in to the register array in rr_cfg_regs.

Test Plan:
- Write 0x1C = 0xA5A5_5A5A, wstrb 4'b0101, AW issued 3 cycles before W -> bvalid 1 cycle after W handshake, bresp 00; read 0x1C returns 0x00A5_005A.
- Write 0x00 = 0x7 -> record_en = replay_en = 1, rr_reset_pulse high exactly 1 cycle; read 0x00 returns 0x3.
- log_cnt = 0x1111_2222_3333_4444; read 0x14, change log_cnt to 0x5555_…, read 0x18 -> 0x3333_4444 then 0x1111_2222.
- Read 0x3C -> rdata 0xDEAD_BEEF, rresp 10. Write 0x04 -> bresp 10, STATUS unchanged.
- Pulse overflow_evt -> STATUS[2] = 1. Write 0x28 = 1 with overflow_evt high in the commit cycle -> remains 1; repeat with it low -> 0.
- bready held low for 10 cycles with a second AW/W pending -> second commit occurs only after the first B handshake. With RR_CFG_WR_COUNT_EN, 0x24 reads 2.

Source files
------------

// File: rtl/rr_cfg_pkg.sv
// rr_cfg_pkg: shared constants for the record/replay configuration register file.
// Holds register byte offsets, CTRL bit indices, AXI response codes, the
// read-back value for unmapped offsets, and a byte-strobe merge helper.
package rr_cfg_pkg;

    // Register byte offsets within the 256-byte decode window
    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_STATUS      = 8'h04;
    localparam logic [7:0] OFF_BUF_BASE_LO = 8'h08;
    localparam logic [7:0] OFF_BUF_BASE_HI = 8'h0C;
    localparam logic [7:0] OFF_BUF_SIZE    = 8'h10;
    localparam logic [7:0] OFF_LOG_CNT_LO  = 8'h14;
    localparam logic [7:0] OFF_LOG_CNT_HI  = 8'h18;
    localparam logic [7:0] OFF_SCRATCH     = 8'h1C;
    localparam logic [7:0] OFF_VERSION     = 8'h20;
    localparam logic [7:0] OFF_WR_CNT      = 8'h24;
    localparam logic [7:0] OFF_OVF_CLR     = 8'h28;

    // CTRL bit positions
    localparam int CTRL_RECORD_EN_BIT = 0;
    localparam int CTRL_REPLAY_EN_BIT = 1;
    localparam int CTRL_RR_RESET_BIT  = 2;
    localparam int OVF_CLR_BIT        = 0;

    localparam logic [1:0]  AXI_RESP_OKAY        = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR      = 2'b10;
    localparam logic [31:0] RR_CFG_UNMAPPED_DATA = 32'hDEAD_BEEF;

    // Replace only the bytes of old_val whose strobe bit is set
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rr_axi_lite_bus_t.sv
// rr_axi_lite_bus_t: 32-bit AXI-lite bus bundle for the record/replay config window.
// modport master : the view taken by the block that terminates the bus
//                  (receives AW/W/AR, drives B/R and the ready signals).
// modport initiator : the view of the requester driving the bus.
interface rr_axi_lite_bus_t;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport initiator (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rr_cfg_axil_slave_if.sv
// rr_cfg_axil_slave_if: AXI-lite handshake engine for rr_cfg_regs.
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid and ready are both high; valid, once raised, holds with stable
// payload until that edge.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   aw*/w*/b*/ar*/r*                  AXI-lite slave channels
//   wr_en, wr_addr, wr_data, wr_strb  one-cycle commit strobe + held write beat
//   wr_err_in                         register array flags the commit as SLVERR
//   rd_en, rd_addr                    one-cycle read strobe + address (AR handshake cycle)
//   rd_data, rd_err_in                read data/error selected by the register array
module rr_cfg_axil_slave_if
    import rr_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    output logic        awready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    output logic        arready,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    input  logic        wr_err_in,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_err_in
);

    logic        aw_held;
    logic        w_held;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;

    assign awready = !aw_held;
    assign wready  = !w_held;
    assign arready = !rvalid;

    // Commit is deferred while a B response is still outstanding
    assign wr_en   = aw_held && w_held && !bvalid;
    assign wr_addr = aw_addr_q;
    assign wr_data = w_data_q;
    assign wr_strb = w_strb_q;

    assign rd_en   = arvalid && !rvalid;
    assign rd_addr = araddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= AXI_RESP_OKAY;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= AXI_RESP_OKAY;
        end else begin
            if (awvalid && !aw_held) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (wvalid && !w_held) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            // wr_en implies both held and no B pending, so it never
            // collides with a capture or a B handshake above/below
            if (wr_en) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_err_in ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (rd_en) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= rd_err_in ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_cfg_regs.sv
// rr_cfg_regs: AXI-lite register file terminating the record/replay
// configuration window (upper 1MB of BAR1). Only addr[7:ADDR_LSB] is decoded.
// Optional build macro RR_CFG_WR_COUNT_EN adds the read-only WR_CNT register
// at 0x24 counting OKAY write commits (saturating); without it 0x24 is unmapped.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_bus         AXI-lite bus from the interconnect (this block responds)
//   record_busy     engine status in
//   replay_busy     engine status in
//   overflow_evt    single-cycle overflow event, sets the sticky STATUS[2]
//   log_cnt         free-running 64-bit log count
//   record_en       CTRL[0]
//   replay_en       CTRL[1]
//   rr_reset_pulse  one-cycle pulse after a CTRL write with bit2 set
//   buf_base        {BUF_BASE_HI, BUF_BASE_LO}
//   buf_size        BUF_SIZE
module rr_cfg_regs
    import rr_cfg_pkg::*;
#(
    parameter logic [31:0] VERSION  = 32'h0001_0000,
    parameter int          ADDR_LSB = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_axi_lite_bus_t.master        cfg_bus,
    input  logic                    record_busy,
    input  logic                    replay_busy,
    input  logic                    overflow_evt,
    input  logic [63:0]             log_cnt,
    output logic                    record_en,
    output logic                    replay_en,
    output logic                    rr_reset_pulse,
    output logic [63:0]             buf_base,
    output logic [31:0]             buf_size
);

    logic        wr_en, wr_err, rd_en, rd_err;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;
    logic [7:0]  wr_off, rd_off;
    logic        wr_ok;

    logic [1:0]  ctrl_q;
    logic [31:0] base_lo_q, base_hi_q, size_q, scratch_q, shadow_q;
    logic        ovf_sticky;
`ifdef RR_CFG_WR_COUNT_EN
    logic [15:0] wr_cnt_q;
`endif

    // Address bits above the decode window alias onto the same registers
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[31:8], rd_addr[31:8]};

    rr_cfg_axil_slave_if u_axil (
        .clk      (clk),
        .rst      (rst),
        .awvalid  (cfg_bus.awvalid),
        .awaddr   (cfg_bus.awaddr),
        .awready  (cfg_bus.awready),
        .wvalid   (cfg_bus.wvalid),
        .wdata    (cfg_bus.wdata),
        .wstrb    (cfg_bus.wstrb),
        .wready   (cfg_bus.wready),
        .bvalid   (cfg_bus.bvalid),
        .bready   (cfg_bus.bready),
        .bresp    (cfg_bus.bresp),
        .arvalid  (cfg_bus.arvalid),
        .araddr   (cfg_bus.araddr),
        .arready  (cfg_bus.arready),
        .rvalid   (cfg_bus.rvalid),
        .rready   (cfg_bus.rready),
        .rdata    (cfg_bus.rdata),
        .rresp    (cfg_bus.rresp),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_err_in(wr_err),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_err_in(rd_err)
    );

    // Byte offset with the sub-word bits forced to zero
    assign wr_off = (wr_addr[7:0] >> ADDR_LSB) << ADDR_LSB;
    assign rd_off = (rd_addr[7:0] >> ADDR_LSB) << ADDR_LSB;

    // Only writable offsets accept a write; RO and unmapped offsets answer SLVERR
    always_comb begin
        wr_err = 1'b1;
        case (wr_off)
            OFF_CTRL, OFF_BUF_BASE_LO, OFF_BUF_BASE_HI,
            OFF_BUF_SIZE, OFF_SCRATCH, OFF_OVF_CLR: wr_err = 1'b0;
            default: wr_err = 1'b1;
        endcase
    end
    assign wr_ok = wr_en && !wr_err;

    always_comb begin
        rd_data = RR_CFG_UNMAPPED_DATA;
        rd_err  = 1'b1;
        case (rd_off)
            OFF_CTRL:        begin rd_data = {30'b0, ctrl_q};                                  rd_err = 1'b0; end
            OFF_STATUS:      begin rd_data = {29'b0, ovf_sticky, replay_busy, record_busy};    rd_err = 1'b0; end
            OFF_BUF_BASE_LO: begin rd_data = base_lo_q;                                        rd_err = 1'b0; end
            OFF_BUF_BASE_HI: begin rd_data = base_hi_q;                                        rd_err = 1'b0; end
            OFF_BUF_SIZE:    begin rd_data = size_q;                                           rd_err = 1'b0; end
            OFF_LOG_CNT_LO:  begin rd_data = log_cnt[31:0];                                    rd_err = 1'b0; end
            OFF_LOG_CNT_HI:  begin rd_data = shadow_q;                                         rd_err = 1'b0; end
            OFF_SCRATCH:     begin rd_data = scratch_q;                                        rd_err = 1'b0; end
            OFF_VERSION:     begin rd_data = VERSION;                                          rd_err = 1'b0; end
            OFF_OVF_CLR:     begin rd_data = 32'h0;                                            rd_err = 1'b0; end
`ifdef RR_CFG_WR_COUNT_EN
            OFF_WR_CNT:      begin rd_data = {16'b0, wr_cnt_q};                                rd_err = 1'b0; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q         <= '0;
            base_lo_q      <= '0;
            base_hi_q      <= '0;
            size_q         <= '0;
            scratch_q      <= '0;
            shadow_q       <= '0;
            ovf_sticky     <= 1'b0;
            rr_reset_pulse <= 1'b0;
`ifdef RR_CFG_WR_COUNT_EN
            wr_cnt_q       <= '0;
`endif
        end else begin
            rr_reset_pulse <= 1'b0;
            if (wr_ok) begin
                case (wr_off)
                    OFF_CTRL: if (wr_strb[0]) begin
                        ctrl_q[CTRL_RECORD_EN_BIT] <= wr_data[CTRL_RECORD_EN_BIT];
                        ctrl_q[CTRL_REPLAY_EN_BIT] <= wr_data[CTRL_REPLAY_EN_BIT];
                        rr_reset_pulse             <= wr_data[CTRL_RR_RESET_BIT];
                    end
                    OFF_BUF_BASE_LO: base_lo_q <= apply_wstrb(base_lo_q, wr_data, wr_strb);
                    OFF_BUF_BASE_HI: base_hi_q <= apply_wstrb(base_hi_q, wr_data, wr_strb);
                    OFF_BUF_SIZE:    size_q    <= apply_wstrb(size_q, wr_data, wr_strb);
                    OFF_SCRATCH:     scratch_q <= apply_wstrb(scratch_q, wr_data, wr_strb);
                    default: ;
                endcase
            end

            // A same-cycle overflow event beats the clear
            if (overflow_evt) begin
                ovf_sticky <= 1'b1;
            end else if (wr_ok && wr_off == OFF_OVF_CLR && wr_strb[0] && wr_data[OVF_CLR_BIT]) begin
                ovf_sticky <= 1'b0;
            end

            // Reading LOG_CNT_LO freezes the upper half so LO/HI form one coherent sample
            if (rd_en && rd_off == OFF_LOG_CNT_LO) begin
                shadow_q <= log_cnt[63:32];
            end

`ifdef RR_CFG_WR_COUNT_EN
            if (wr_ok && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
`endif
        end
    end

    assign record_en = ctrl_q[CTRL_RECORD_EN_BIT];
    assign replay_en = ctrl_q[CTRL_REPLAY_EN_BIT];
    assign buf_base  = {base_hi_q, base_lo_q};
    assign buf_size  = size_q;

endmodule

// File: tb/tb_rr_cfg_regs.sv
// tb_rr_cfg_regs: directed plus randomized bench for rr_cfg_regs with a
// behavioural register-map model.
module tb_rr_cfg_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        record_busy = 1'b0;
    logic        replay_busy = 1'b0;
    logic        overflow_evt = 1'b0;
    logic [63:0] log_cnt = 64'h0;
    logic        record_en, replay_en, rr_reset_pulse;
    logic [63:0] buf_base;
    logic [31:0] buf_size;

    int n_tests = 0;
    int n_fail  = 0;

    rr_axi_lite_bus_t bus ();

    rr_cfg_regs dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_bus       (bus),
        .record_busy   (record_busy),
        .replay_busy   (replay_busy),
        .overflow_evt  (overflow_evt),
        .log_cnt       (log_cnt),
        .record_en     (record_en),
        .replay_en     (replay_en),
        .rr_reset_pulse(rr_reset_pulse),
        .buf_base      (buf_base),
        .buf_size      (buf_size)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0]  m_ctrl;
    logic [31:0] m_base_lo, m_base_hi, m_size, m_scratch, m_shadow;
    logic        m_ovf;
    logic [15:0] m_wr_cnt;

    task automatic model_reset();
        m_ctrl = 0; m_base_lo = 0; m_base_hi = 0; m_size = 0;
        m_scratch = 0; m_shadow = 0; m_ovf = 0; m_wr_cnt = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic pulse);
        logic [7:0] off;
        off = a[7:0] & 8'hFC;
        resp = 2'b10;
        pulse = 1'b0;
        case (off)
            8'h00: begin resp = 2'b00; if (s[0]) begin m_ctrl = d[1:0]; pulse = d[2]; end end
            8'h08: begin resp = 2'b00; m_base_lo = merge(m_base_lo, d, s); end
            8'h0C: begin resp = 2'b00; m_base_hi = merge(m_base_hi, d, s); end
            8'h10: begin resp = 2'b00; m_size    = merge(m_size, d, s); end
            8'h1C: begin resp = 2'b00; m_scratch = merge(m_scratch, d, s); end
            8'h28: begin resp = 2'b00; if (s[0] && d[0]) m_ovf = 1'b0; end
            default: ;
        endcase
        if (resp == 2'b00 && m_wr_cnt != 16'hFFFF) m_wr_cnt = m_wr_cnt + 1;
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic [7:0] off;
        off = a[7:0] & 8'hFC;
        d = 32'hDEAD_BEEF;
        resp = 2'b00;
        case (off)
            8'h00: d = {30'b0, m_ctrl};
            8'h04: d = {29'b0, m_ovf, replay_busy, record_busy};
            8'h08: d = m_base_lo;
            8'h0C: d = m_base_hi;
            8'h10: d = m_size;
            8'h14: begin d = log_cnt[31:0]; m_shadow = log_cnt[63:32]; end
            8'h18: d = m_shadow;
            8'h1C: d = m_scratch;
            8'h20: d = 32'h0001_0000;
            8'h28: d = 32'h0;
`ifdef RR_CFG_WR_COUNT_EN
            8'h24: d = {16'b0, m_wr_cnt};
`endif
            default: resp = 2'b10;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ctrl"}, {record_en, replay_en}, {m_ctrl[0], m_ctrl[1]});
        check({tag, "_base"}, buf_base, {m_base_hi, m_base_lo});
        check({tag, "_size"}, buf_size, m_size);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    // Presents AW and W together; ovf_commit drives overflow_evt during the commit cycle.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic ovf_commit, output logic [1:0] resp, output logic pulse);
        logic aw_done, w_done, hs_aw, hs_w;
        int i;
        aw_done = 0; w_done = 0; resp = 2'bxx; pulse = 1'b0;
        bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
        bus.bready = 1;
        i = 0;
        while (!(aw_done && w_done) && i < 20) begin
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            tick();
            if (hs_aw) begin aw_done = 1; bus.awvalid = 0; end
            if (hs_w)  begin w_done = 1;  bus.wvalid = 0; end
            i++;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        overflow_evt = ovf_commit;
        i = 0;
        while (!bus.bvalid && i < 20) begin
            tick();
            overflow_evt = 1'b0;
            i++;
        end
        overflow_evt = 1'b0;
        check("wr_b_timeout", bus.bvalid, 1'b1);
        resp = bus.bresp;
        pulse = rr_reset_pulse;
        tick();
        bus.bready = 0;
        check("wr_b_done", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs;
        int i;
        bus.araddr = a; bus.arvalid = 1; bus.rready = 0;
        hs = 0; i = 0;
        while (!hs && i < 20) begin
            hs = bus.arvalid && bus.arready;
            tick();
            i++;
        end
        bus.arvalid = 0;
        check("rd_latency", bus.rvalid, 1'b1);
        d = bus.rdata;
        resp = bus.rresp;
        tick();
        check("rd_hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, d, resp});
        bus.rready = 1;
        tick();
        bus.rready = 0;
        check("rd_done", bus.rvalid, 1'b0);
    endtask

    // Read and compare against the model
    task automatic read_check(input string tag, input logic [31:0] a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        model_read(a, ed, er);
        axi_read(a, d, r);
        check({tag, "_data"}, d, ed);
        check({tag, "_resp"}, r, er);
    endtask

    task automatic write_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        logic [1:0] r, er;
        logic p, ep;
        axi_write(a, d, s, 1'b0, r, p);
        model_write(a, d, s, er, ep);
        check({tag, "_bresp"}, r, er);
        check({tag, "_pulse"}, p, ep);
        check({tag, "_pulse_off"}, rr_reset_pulse, 1'b0);
        check_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r, er;
        logic        p, ep;
        logic [31:0] old_size;

        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;
        model_reset();
        repeat (3) tick();
        check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_resp", {bus.bresp, bus.rresp}, 4'b0000);
        check("rst_pulse", rr_reset_pulse, 1'b0);
        check_outputs("rst");
        rst = 0;
        tick();

        // AW three cycles ahead of W, partial strobe
        bus.awaddr = 32'h1C; bus.awvalid = 1; bus.bready = 0;
        tick();
        bus.awvalid = 0;
        check("stag_aw_held", bus.awready, 1'b0);
        tick(); tick();
        check("stag_no_b_early", bus.bvalid, 1'b0);
        bus.wdata = 32'hA5A5_5A5A; bus.wstrb = 4'b0101; bus.wvalid = 1;
        tick();
        bus.wvalid = 0;
        check("stag_commit_cycle", bus.bvalid, 1'b0);
        tick();
        check("stag_bvalid", {bus.bvalid, bus.bresp}, 3'b100);
        bus.bready = 1;
        tick();
        bus.bready = 0;
        model_write(32'h1C, 32'hA5A5_5A5A, 4'b0101, er, ep);
        axi_read(32'h1C, d, r);
        check("stag_scratch", d, 32'h00A5_005A);
        check("stag_scratch_model", d, m_scratch);

        // CTRL with reset pulse
        axi_write(32'h00, 32'h7, 4'hF, 1'b0, r, p);
        model_write(32'h00, 32'h7, 4'hF, er, ep);
        check("ctrl_bresp", r, 2'b00);
        check("ctrl_pulse", p, 1'b1);
        check("ctrl_pulse_once", rr_reset_pulse, 1'b0);
        check("ctrl_en", {record_en, replay_en}, 2'b11);
        read_check("ctrl_rd", 32'h00);

        // LOG_CNT snapshot coherence
        log_cnt = 64'h1111_2222_3333_4444;
        axi_read(32'h14, d, r);
        model_read(32'h14, d, r);
        check("log_lo", d, 32'h3333_4444);
        log_cnt = 64'h5555_6666_7777_8888;
        axi_read(32'h18, d, r);
        check("log_hi_shadow", d, 32'h1111_2222);

        // Unmapped read, write to RO register
        axi_read(32'h3C, d, r);
        check("unmapped_data", d, 32'hDEAD_BEEF);
        check("unmapped_resp", r, 2'b10);
        record_busy = 1;
        write_check("ro_status", 32'h04, 32'hFFFF_FFFF, 4'hF);
        read_check("status_after_ro", 32'h04);
        read_check("version", 32'h20);

        // Sticky overflow and clear races
        overflow_evt = 1;
        tick();
        overflow_evt = 0;
        m_ovf = 1;
        read_check("ovf_set", 32'h04);
        axi_write(32'h28, 32'h1, 4'hF, 1'b1, r, p);
        model_write(32'h28, 32'h1, 4'hF, er, ep);
        m_ovf = 1;
        check("ovf_clr_race_bresp", r, 2'b00);
        read_check("ovf_set_wins", 32'h04);
        axi_write(32'h28, 32'h1, 4'hF, 1'b0, r, p);
        model_write(32'h28, 32'h1, 4'hF, er, ep);
        read_check("ovf_cleared", 32'h04);

        // B back-pressure with a second write queued behind it
        old_size = m_size;
        bus.awaddr = 32'h1C; bus.awvalid = 1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
        bus.wvalid = 1; bus.bready = 0;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        tick();
        check("bp_first_b", bus.bvalid, 1'b1);
        model_write(32'h1C, 32'h1234_5678, 4'hF, er, ep);
        bus.awaddr = 32'h10; bus.awvalid = 1; bus.wdata = 32'hCAFE_0010; bus.wvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_b", bus.bvalid, 1'b1);
            check("bp_hold_size", buf_size, old_size);
        end
        check("bp_second_held", {bus.awready, bus.wready}, 2'b00);
        bus.bready = 1;
        tick();
        bus.bready = 0;
        check("bp_after_hs", {bus.bvalid, buf_size}, {1'b0, old_size});
        tick();
        check("bp_second_b", {bus.bvalid, bus.bresp}, 3'b100);
        check("bp_second_size", buf_size, 32'hCAFE_0010);
        model_write(32'h10, 32'hCAFE_0010, 4'hF, er, ep);
        bus.bready = 1;
        tick();
        bus.bready = 0;
        read_check("bp_scratch", 32'h1C);
        read_check("wr_cnt", 32'h24);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = {12'h0, 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 15) * 4)};
            a[1:0] = 2'($urandom_range(0, 3));
            log_cnt = {$urandom, $urandom};
            record_busy = 1'($urandom_range(0, 1));
            replay_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                write_check("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                read_check("rnd_rd", a);
            end
        end
        read_check("rnd_wr_cnt", 32'h24);
        read_check("rnd_log_lo", 32'h14);
        read_check("rnd_log_hi", 32'h18);

        // Reset in the middle of outstanding B and R
        write_check("pre_rst", 32'h1C, 32'h0BAD_F00D, 4'hF);
        bus.araddr = 32'h1C; bus.arvalid = 1; bus.rready = 0;
        bus.awaddr = 32'h08; bus.awvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        bus.wvalid = 1; bus.bready = 0;
        tick();
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        tick();
        check("mid_pending", {bus.bvalid, bus.rvalid}, 2'b11);
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        check("mid_rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
        check("mid_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        check_outputs("mid_rst");
        read_check("mid_rst_scratch", 32'h1C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
